// File: rtl/rhythm_window_analyzer_pkg.sv
// Shared beat-class encoding, FSM state type and confidence scale for the
// rhythm window analyzer.
package rhythm_window_analyzer_pkg;

  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_BRADY  = 2'b01;
  localparam logic [1:0] CLS_TACHY  = 2'b10;
  localparam logic [1:0] CLS_IRREG  = 2'b11;

  localparam int CONF_SCALE = 255;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rhythm_window_analyzer_if.sv
// Beat input and diagnosis output bundle of the rhythm window analyzer.
interface rhythm_window_analyzer_if;

  // Beats are one-cycle strobes with no back-pressure. A result transfers on
  // any edge where diag_valid && diag_ready; while diag_valid is high and
  // diag_ready is low, final_diag and confidence hold unless a newer result
  // overwrites them.
  logic       beat_valid;
  logic [1:0] beat_class;
  logic       diag_ready;
  logic       diag_valid;
  logic [1:0] final_diag;
  logic [7:0] confidence;

  modport master (
    output beat_valid, beat_class, diag_ready,
    input  diag_valid, final_diag, confidence
  );

  modport slave (
    input  beat_valid, beat_class, diag_ready,
    output diag_valid, final_diag, confidence
  );

endinterface

// File: rtl/rhythm_window_analyzer_dominant_select.sv
// Combinational pick of the most frequent beat class; equal counts favour
// Irregular, then Tachy, then Brady, then Normal.
module dominant_select
  import rhythm_window_analyzer_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] cnt_normal,
  input  logic [CW-1:0] cnt_brady,
  input  logic [CW-1:0] cnt_tachy,
  input  logic [CW-1:0] cnt_irreg,
  output logic [1:0]    dom_cls,
  output logic [CW-1:0] dom_cnt
);

  // Start from the highest-priority class; only a strictly larger count wins.
  always_comb begin
    dom_cls = CLS_IRREG;
    dom_cnt = cnt_irreg;
    if (cnt_tachy > dom_cnt) begin
      dom_cls = CLS_TACHY;
      dom_cnt = cnt_tachy;
    end
    if (cnt_brady > dom_cnt) begin
      dom_cls = CLS_BRADY;
      dom_cnt = cnt_brady;
    end
    if (cnt_normal > dom_cnt) begin
      dom_cls = CLS_NORMAL;
      dom_cnt = cnt_normal;
    end
  end

endmodule

// File: rtl/rhythm_window_analyzer.sv
// Sliding/block window of classified beats with running per-class counts,
// dominant-class diagnosis and a valid/ready result port.
module rhythm_window_analyzer
  import rhythm_window_analyzer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MIN_FORCE = 4,
  parameter int CW        = $clog2(DEPTH) + 1
) (
  input  logic                      clk_div,
  input  logic                      rst_n,
  rhythm_window_analyzer_if.slave   bus,
  input  logic                      mode,
  input  logic                      force_anlz,
  input  logic                      clear,
  output logic [CW-1:0]             fill_cnt,
  output logic                      overrun,
  output state_t                    fsm_state
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]    window_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] blk_cnt_q;
  logic [CW-1:0] cnt_q [4];
  state_t        state_q;
  logic          force_q;
  logic          anl_pend_q;
  logic          diag_valid_q;
  logic [1:0]    final_diag_q;
  logic [7:0]    confidence_q;

  logic          full;
  logic          beat_acc;
  logic          force_rise;
  logic          fill_done;
  logic [CW-1:0] fill_nxt;
  logic [1:0]    evict_cls;
  logic          auto_trig;
  logic          force_trig;
  logic          trigger;
  logic [1:0]    dom_cls;
  logic [CW-1:0] dom_cnt;
  logic [15:0]   conf_prod;
  logic [7:0]    conf_val;

  assign full       = (fill_cnt == FULL);
  assign beat_acc   = bus.beat_valid & ~clear;
  assign force_rise = force_anlz & ~force_q;
  assign fill_done  = beat_acc && (fill_cnt == FULL - CW'(1));
  assign fill_nxt   = (beat_acc && !full) ? fill_cnt + CW'(1) : fill_cnt;
  // Once full, the write pointer sits on the oldest entry, which this beat evicts.
  assign evict_cls  = window_q[wr_ptr_q];

  // The filling beat always analyses; afterwards BLOCK mode waits DEPTH beats.
  assign auto_trig  = beat_acc && (fill_done ||
                      (full && (!mode || blk_cnt_q == PW'(DEPTH - 1))));
  assign force_trig = force_rise && (fill_nxt >= CW'(MIN_FORCE));
  assign trigger    = !clear && (auto_trig || force_trig);

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      fill_cnt  <= '0;
      wr_ptr_q  <= '0;
      blk_cnt_q <= '0;
    end else if (clear) begin
      state_q   <= ST_FILL;
      fill_cnt  <= '0;
      wr_ptr_q  <= '0;
      blk_cnt_q <= '0;
    end else if (beat_acc) begin
      wr_ptr_q <= wr_ptr_q + PW'(1);
      if (!full) fill_cnt <= fill_cnt + CW'(1);
      if (fill_done) begin
        state_q   <= ST_RUN;
        blk_cnt_q <= '0;
      end else if (full) begin
        blk_cnt_q <= blk_cnt_q + PW'(1);
      end
    end
  end

  assign fsm_state = state_q;

  always_ff @(posedge clk_div) begin
    if (beat_acc) window_q[wr_ptr_q] <= bus.beat_class;
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) cnt_q[c] <= '0;
    end else if (clear) begin
      for (int c = 0; c < 4; c++) cnt_q[c] <= '0;
    end else if (beat_acc) begin
      for (int c = 0; c < 4; c++) begin
        if (bus.beat_class == 2'(c) && !(full && evict_cls == 2'(c)))
          cnt_q[c] <= cnt_q[c] + CW'(1);
        else if (bus.beat_class != 2'(c) && full && evict_cls == 2'(c))
          cnt_q[c] <= cnt_q[c] - CW'(1);
      end
    end
  end

  dominant_select #(.CW(CW)) u_dom (
    .cnt_normal (cnt_q[0]),
    .cnt_brady  (cnt_q[1]),
    .cnt_tachy  (cnt_q[2]),
    .cnt_irreg  (cnt_q[3]),
    .dom_cls    (dom_cls),
    .dom_cnt    (dom_cnt)
  );

  // Denominator is always DEPTH, so partial windows report a reduced share.
  assign conf_prod = 16'(dom_cnt) * 16'(CONF_SCALE);
  assign conf_val  = 8'(conf_prod >> PW);

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) force_q <= 1'b0;
    else        force_q <= force_anlz;
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      anl_pend_q   <= 1'b0;
      diag_valid_q <= 1'b0;
      final_diag_q <= CLS_NORMAL;
      confidence_q <= '0;
      overrun      <= 1'b0;
    end else if (clear) begin
      anl_pend_q   <= 1'b0;
      diag_valid_q <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      anl_pend_q <= trigger;
      if (anl_pend_q) begin
        if (diag_valid_q && !bus.diag_ready) overrun <= 1'b1;
        diag_valid_q <= 1'b1;
        final_diag_q <= dom_cls;
        confidence_q <= conf_val;
      end else if (diag_valid_q && bus.diag_ready) begin
        diag_valid_q <= 1'b0;
      end
    end
  end

  assign bus.diag_valid = diag_valid_q;
  assign bus.final_diag = final_diag_q;
  assign bus.confidence = confidence_q;

endmodule

// File: tb/tb_rhythm_window_analyzer.sv
// Self-checking bench for rhythm_window_analyzer: directed scenarios plus a
// long randomized run against a queue-based window model.
module tb_rhythm_window_analyzer;
  import rhythm_window_analyzer_pkg::*;

  localparam int DEPTH     = 8;
  localparam int MIN_FORCE = 4;
  localparam int CW        = 4;

  logic          clk_div = 1'b0;
  logic          rst_n;
  logic          mode;
  logic          force_anlz;
  logic          clear;
  logic [CW-1:0] fill_cnt;
  logic          overrun;
  state_t        fsm_state;

  rhythm_window_analyzer_if bus();

  rhythm_window_analyzer #(.DEPTH(DEPTH), .MIN_FORCE(MIN_FORCE), .CW(CW)) dut (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .bus        (bus),
    .mode       (mode),
    .force_anlz (force_anlz),
    .clear      (clear),
    .fill_cnt   (fill_cnt),
    .overrun    (overrun),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_div = ~clk_div;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  logic [1:0] win[$];
  logic [9:0] exp_q[$];
  int         m_nfull;
  bit         m_prev_force;
  bit         m_valid;
  bit         m_overrun;
  logic [1:0] m_diag;
  logic [7:0] m_conf;

  function automatic int model_count(input int c);
    int n = 0;
    foreach (win[i]) if (int'(win[i]) == c) n++;
    return n;
  endfunction

  function automatic logic [9:0] model_result();
    int cnt[4];
    int best;
    int conf;
    for (int c = 0; c < 4; c++) cnt[c] = model_count(c);
    best = 3;
    for (int c = 2; c >= 0; c--) if (cnt[c] > cnt[best]) best = c;
    conf = (cnt[best] * 255) / DEPTH;
    return {2'(best), 8'(conf)};
  endfunction

  task automatic model_reset();
    win.delete();
    exp_q.delete();
    m_nfull      = 0;
    m_prev_force = 0;
    m_valid      = 0;
    m_overrun    = 0;
    m_diag       = 2'b00;
    m_conf       = 8'd0;
  endtask

  task automatic model_edge(input bit bv, input logic [1:0] cls, input bit frc,
                            input bit clr, input bit rdy);
    logic [9:0] r;
    bit trig;
    if (clr) begin
      m_valid   = 0;
      m_overrun = 0;
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      if (m_valid && !rdy) m_overrun = 1;
      m_valid = 1;
      m_diag  = r[9:8];
      m_conf  = r[7:0];
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (clr) begin
      win.delete();
      m_nfull = 0;
    end else begin
      trig = 0;
      if (bv) begin
        win.push_back(cls);
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
          m_nfull++;
          if (mode == 1'b0 || ((m_nfull - 1) % DEPTH) == 0) trig = 1;
        end
      end
      if (frc && !m_prev_force && win.size() >= MIN_FORCE) trig = 1;
      if (trig) exp_q.push_back(model_result());
    end
    m_prev_force = frc;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit bv, input logic [1:0] cls, input bit frc,
                      input bit clr, input bit rdy);
    bus.beat_valid = bv;
    bus.beat_class = cls;
    force_anlz     = frc;
    clear          = clr;
    bus.diag_ready = rdy;
    @(posedge clk_div);
    model_edge(bv, cls, frc, clr, rdy);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    bus.beat_valid = 1'b0;
    bus.beat_class = 2'b00;
    bus.diag_ready = 1'b0;
    force_anlz     = 1'b0;
    clear          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_div);
    @(negedge clk_div);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mode = 1'b0;
    apply_reset();
    tests_run++;
    if (bus.diag_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %0b want 0", bus.diag_valid);
    end
    tests_run++;
    if (bus.final_diag !== 2'b00) begin
      tests_failed++; $display("FAIL reset_diag: got %0b want 00", bus.final_diag);
    end
    tests_run++;
    if (bus.confidence !== 8'd0) begin
      tests_failed++; $display("FAIL reset_conf: got %0d want 0", bus.confidence);
    end
    tests_run++;
    if (fill_cnt !== '0) begin
      tests_failed++; $display("FAIL reset_fill: got %0d want 0", fill_cnt);
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overrun: got %0b want 0", overrun);
    end
    tests_run++;
    if (fsm_state !== ST_FILL) begin
      tests_failed++; $display("FAIL reset_state: got %0d want FILL", fsm_state);
    end
  endtask

  task automatic test_normal_fill();
    mode = 1'b0;
    step(0, 2'b00, 0, 1, 1);
    for (int i = 0; i < DEPTH; i++) step(1, CLS_NORMAL, 0, 0, 1);
    tests_run++;
    if (bus.diag_valid !== 1'b0) begin
      tests_failed++; $display("FAIL normal_early: got valid %0b one edge after beat, want 0", bus.diag_valid);
    end
    step(0, 2'b00, 0, 0, 1);
    tests_run++;
    if (bus.diag_valid !== 1'b1 || bus.final_diag !== 2'b00 || bus.confidence !== 8'd255) begin
      tests_failed++;
      $display("FAIL normal_result: got v=%0b d=%0b c=%0d want v=1 d=00 c=255",
               bus.diag_valid, bus.final_diag, bus.confidence);
    end
    tests_run++;
    if (fsm_state !== ST_RUN || fill_cnt !== 4'd8) begin
      tests_failed++; $display("FAIL normal_run: got state=%0d fill=%0d want RUN 8", fsm_state, fill_cnt);
    end
    step(0, 2'b00, 0, 0, 1);
    tests_run++;
    if (bus.diag_valid !== 1'b0) begin
      tests_failed++; $display("FAIL normal_accept: got valid %0b after accept, want 0", bus.diag_valid);
    end
  endtask

  task automatic test_tie();
    mode = 1'b0;
    step(0, 2'b00, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, CLS_TACHY, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, CLS_BRADY, 0, 0, 1);
    step(1, CLS_BRADY, 0, 0, 1);
    tests_run++;
    if (bus.final_diag !== 2'b10 || bus.confidence !== 8'd159) begin
      tests_failed++; $display("FAIL tie_first: got d=%0b c=%0d want d=10 c=159", bus.final_diag, bus.confidence);
    end
    step(0, 2'b00, 0, 0, 1);
    tests_run++;
    if (bus.diag_valid !== 1'b1 || bus.final_diag !== 2'b10 || bus.confidence !== 8'd127) begin
      tests_failed++;
      $display("FAIL tie_result: got v=%0b d=%0b c=%0d want v=1 d=10 c=127",
               bus.diag_valid, bus.final_diag, bus.confidence);
    end
    tests_run++;
    if (dut.cnt_q[2] !== 4'(model_count(2)) || dut.cnt_q[1] !== 4'(model_count(1))) begin
      tests_failed++; $display("FAIL tie_counts: got tachy=%0d brady=%0d want %0d %0d",
                               dut.cnt_q[2], dut.cnt_q[1], model_count(2), model_count(1));
    end
  endtask

  task automatic test_force();
    mode = 1'b0;
    step(0, 2'b00, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, CLS_IRREG, 0, 0, 1);
    step(0, 2'b00, 1, 0, 1);
    step(0, 2'b00, 0, 0, 1);
    step(0, 2'b00, 0, 0, 1);
    tests_run++;
    if (bus.diag_valid !== 1'b0) begin
      tests_failed++; $display("FAIL force_short: got valid %0b with 3 beats, want 0", bus.diag_valid);
    end
    step(1, CLS_IRREG, 1, 0, 0);
    tests_run++;
    if (bus.diag_valid !== 1'b0) begin
      tests_failed++; $display("FAIL force_early: got valid %0b, want 0", bus.diag_valid);
    end
    step(0, 2'b00, 1, 0, 0);
    tests_run++;
    if (bus.diag_valid !== 1'b1 || bus.final_diag !== 2'b11 || bus.confidence !== 8'd127) begin
      tests_failed++;
      $display("FAIL force_result: got v=%0b d=%0b c=%0d want v=1 d=11 c=127",
               bus.diag_valid, bus.final_diag, bus.confidence);
    end
    step(0, 2'b00, 1, 0, 0);
    step(0, 2'b00, 0, 0, 0);
    tests_run++;
    if (bus.diag_valid !== 1'b1 || bus.final_diag !== 2'b11 || bus.confidence !== 8'd127) begin
      tests_failed++;
      $display("FAIL force_hold: got v=%0b d=%0b c=%0d want v=1 d=11 c=127",
               bus.diag_valid, bus.final_diag, bus.confidence);
    end
    step(0, 2'b00, 0, 0, 1);
    tests_run++;
    if (bus.diag_valid !== 1'b0) begin
      tests_failed++; $display("FAIL force_accept: got valid %0b, want 0", bus.diag_valid);
    end
  endtask

  task automatic test_block();
    logic [1:0] held_d;
    logic [7:0] held_c;
    mode = 1'b1;
    step(0, 2'b00, 0, 1, 0);
    for (int b = 1; b <= 3 * DEPTH; b++) begin
      step(1, 2'($urandom_range(0, 3)), 0, 0, 0);
      tests_run++;
      if (bus.diag_valid !== m_valid || overrun !== m_overrun) begin
        tests_failed++; $display("FAIL block_flags beat %0d: got v=%0b o=%0b want v=%0b o=%0b",
                                 b, bus.diag_valid, overrun, m_valid, m_overrun);
      end
      if (m_valid) begin
        tests_run++;
        if (bus.final_diag !== m_diag || bus.confidence !== m_conf) begin
          tests_failed++; $display("FAIL block_value beat %0d: got d=%0b c=%0d want d=%0b c=%0d",
                                   b, bus.final_diag, bus.confidence, m_diag, m_conf);
        end
      end
      if (b == 8) begin
        tests_run++;
        if (bus.diag_valid !== 1'b0) begin
          tests_failed++; $display("FAIL block_early: got valid %0b at beat 8, want 0", bus.diag_valid);
        end
      end
      if (b == 9) begin
        held_d = m_diag;
        held_c = m_conf;
      end
      if (b == 16) begin
        tests_run++;
        if (bus.diag_valid !== 1'b1 || bus.final_diag !== held_d || bus.confidence !== held_c) begin
          tests_failed++; $display("FAIL block_stable: got v=%0b d=%0b c=%0d want v=1 d=%0b c=%0d",
                                   bus.diag_valid, bus.final_diag, bus.confidence, held_d, held_c);
        end
      end
      if (b == 17) begin
        tests_run++;
        if (overrun !== 1'b1) begin
          tests_failed++; $display("FAIL block_overrun: got %0b after beat 16 result, want 1", overrun);
        end
      end
    end
    step(0, 2'b00, 0, 0, 0);
    tests_run++;
    if (bus.diag_valid !== 1'b1 || bus.final_diag !== m_diag || bus.confidence !== m_conf || !m_valid) begin
      tests_failed++; $display("FAIL block_last: got v=%0b d=%0b c=%0d want v=1 d=%0b c=%0d",
                               bus.diag_valid, bus.final_diag, bus.confidence, m_diag, m_conf);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0;
    step(0, 2'b00, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, CLS_TACHY, 0, 0, 1);
    step(1, CLS_TACHY, 1, 0, 1);
    rst_n = 1'b0;
    model_reset();
    #3;
    tests_run++;
    if (bus.diag_valid !== 1'b0 || fill_cnt !== '0) begin
      tests_failed++; $display("FAIL rstmid_async: got v=%0b fill=%0d want 0 0", bus.diag_valid, fill_cnt);
    end
    @(negedge clk_div);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b00, 0, 0, 0);
      tests_run++;
      if (bus.diag_valid !== 1'b0 || bus.final_diag !== 2'b00 || bus.confidence !== 8'd0 ||
          fill_cnt !== '0 || overrun !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_quiet cyc %0d: got v=%0b d=%0b c=%0d fill=%0d o=%0b want all 0",
                 i, bus.diag_valid, bus.final_diag, bus.confidence, fill_cnt, overrun);
      end
    end
  endtask

  task automatic test_random();
    bit frc_lvl = 0;
    bit clr;
    int sum;
    state_t es;
    mode = 1'b0;
    step(0, 2'b00, 0, 1, 1);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      clr = ($urandom_range(0, 199) == 0);
      if (clr) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) frc_lvl = ~frc_lvl;
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), frc_lvl, clr,
           ($urandom_range(0, 3) != 0));
      tests_run++;
      if (bus.diag_valid !== m_valid || overrun !== m_overrun) begin
        tests_failed++; $display("FAIL rand_flags cyc %0d: got v=%0b o=%0b want v=%0b o=%0b",
                                 cyc, bus.diag_valid, overrun, m_valid, m_overrun);
      end
      if (m_valid) begin
        tests_run++;
        if (bus.final_diag !== m_diag || bus.confidence !== m_conf) begin
          tests_failed++; $display("FAIL rand_value cyc %0d: got d=%0b c=%0d want d=%0b c=%0d",
                                   cyc, bus.final_diag, bus.confidence, m_diag, m_conf);
        end
      end
      es = (win.size() == DEPTH) ? ST_RUN : ST_FILL;
      tests_run++;
      if (fill_cnt !== 4'(win.size()) || fsm_state !== es) begin
        tests_failed++; $display("FAIL rand_fill cyc %0d: got fill=%0d st=%0d want fill=%0d st=%0d",
                                 cyc, fill_cnt, fsm_state, win.size(), es);
      end
      sum = int'(dut.cnt_q[0]) + int'(dut.cnt_q[1]) + int'(dut.cnt_q[2]) + int'(dut.cnt_q[3]);
      tests_run++;
      if (sum != win.size() || dut.cnt_q[0] !== 4'(model_count(0)) || dut.cnt_q[1] !== 4'(model_count(1)) ||
          dut.cnt_q[2] !== 4'(model_count(2)) || dut.cnt_q[3] !== 4'(model_count(3))) begin
        tests_failed++;
        $display("FAIL rand_counts cyc %0d: got %0d/%0d/%0d/%0d sum=%0d want %0d/%0d/%0d/%0d sum=%0d",
                 cyc, dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2], dut.cnt_q[3], sum,
                 model_count(0), model_count(1), model_count(2), model_count(3), win.size());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_normal_fill();
    test_tie();
    test_force();
    test_block();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
